// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the TS packet multiplexer.
package ts_pkg;

  localparam int          TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } ts_state_e;

endpackage

// File: rtl/ts_packet_mux_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr_i, or fixed priority (lowest index).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic          mode_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic found;

  // First pass (round-robin only) searches at/after ptr_i; second pass picks the
  // lowest requester, covering both the RR wrap-around and fixed priority.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    if (!mode_i) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && req_i[k] && (IW'(k) >= ptr_i)) begin
          found      = 1'b1;
          idx_o      = IW'(k);
          grant_o[k] = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_i[k]) begin
        found      = 1'b1;
        idx_o      = IW'(k);
        grant_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ts_packet_mux.sv
// N-channel MPEG-2 TS packet multiplexer; switches channels only at packet boundaries.
module ts_packet_mux
  import ts_pkg::*;
#(
  parameter  int                    DATA_WIDTH = 8,
  parameter  int                    NUM_CH     = 4,
  parameter  int                    PKT_LEN    = TS_PKT_LEN,
  parameter  logic [DATA_WIDTH-1:0] SYNC_BYTE  = DATA_WIDTH'(TS_SYNC_BYTE),
  localparam int                    CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         arb_mode,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [CH_W-1:0]              out_ch,
  output logic                         sync_err,
  output logic                         busy
);

  localparam int              CNT_W    = $clog2(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  ts_state_e             state_q, state_d;
  logic [CH_W-1:0]       sel_q, sel_d, rr_ptr_q, rr_ptr_d, grant_idx;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CH-1:0]     req, bad, grant;
  logic [DATA_WIDTH-1:0] sel_byte;
  logic                  sel_valid, load_out, accept;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  sync_err_q, sync_err_d;

  // Classify channel heads (sync vs. junk) and pick out the selected channel's lane.
  always_comb begin
    req       = '0;
    bad       = '0;
    sel_byte  = '0;
    sel_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (in_valid[k] && ch_enable[k]) begin
        if (in_data[k*DATA_WIDTH +: DATA_WIDTH] == SYNC_BYTE) req[k] = 1'b1;
        else                                                  bad[k] = 1'b1;
      end
      if (CH_W'(k) == sel_q) begin
        sel_byte  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = in_valid[k];
      end
    end
  end

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req_i   (req),
    .mode_i  (arb_mode),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Next-state logic: arbitration in IDLE, byte forwarding and counting in XFER.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    in_ready   = '0;
    accept     = 1'b0;
    sync_err_d = 1'b0;
    load_out   = !out_valid_q || out_ready;
    unique case (state_q)
      IDLE: begin
        in_ready   = bad;
        sync_err_d = |bad;
        if (|grant) begin
          sel_d   = grant_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          in_ready[k] = (CH_W'(k) == sel_q) && load_out;
        end
        accept = sel_valid && load_out;
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d    = '0;
            state_d  = IDLE;
            rr_ptr_d = (sel_q == LAST_CH) ? '0 : sel_q + CH_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // No handshake may complete while reset is held.
    if (rst) in_ready = '0;
  end

  // Output register: loads when empty or drained, otherwise holds everything.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_ch_d    = out_ch_q;
    if (load_out) begin
      out_valid_d = accept;
      out_sop_d   = accept && (cnt_q == '0);
      out_eop_d   = accept && (cnt_q == LAST_CNT);
      if (accept) begin
        out_data_d = sel_byte;
        out_ch_d   = sel_q;
      end
    end
  end

  // State, counters and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_ch_q    <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_ch_q    <= out_ch_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_ch    = out_ch_q;
  assign sync_err  = sync_err_q;
  assign busy      = (state_q == XFER);

endmodule

// File: tb/tb_ts_packet_mux.sv
// Scoreboard bench for ts_packet_mux: directed packets per channel, expected bytes queued.
module tb_ts_packet_mux;

  localparam int NCH = 4;
  localparam int PL  = 188;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       sop;
    logic       eop;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH*8-1:0] in_data = '0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH-1:0] in_ready;
  logic [NCH-1:0] ch_enable = '0;
  logic           arb_mode = 1'b0;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_sop, out_eop;
  logic [1:0]     out_ch;
  logic           sync_err, busy;

  exp_t       exp_q[$];
  logic [7:0] srcq[NCH][$];
  int         checks = 0;
  int         errors = 0;
  int         pops = 0;
  int         serr_cnt = 0;
  int         cyc = 0;
  int         last_eop = 0;
  logic       have_eop = 1'b0;
  logic       gap_chk = 1'b0;
  logic       rand_rdy = 1'b0;

  ts_packet_mux dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ch_enable(ch_enable), .arb_mode(arb_mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_ch(out_ch),
    .sync_err(sync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pb(input int seed, input int i);
    if (i == 0) return 8'h47;
    return 8'(seed + i);
  endfunction

  // Source driver: pops bytes accepted at the edge, then presents the new heads.
  initial begin
    logic [NCH-1:0] fire;
    forever begin
      @(negedge clk);
      fire = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (fire[k] && srcq[k].size() != 0) void'(srcq[k].pop_front());
        in_valid[k]       = (srcq[k].size() != 0);
        in_data[k*8 +: 8] = (srcq[k].size() != 0) ? srcq[k][0] : 8'h00;
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall-hold, inter-packet gap and sync_err counting.
  initial begin
    exp_t e, got, prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
        have_eop   = 1'b0;
      end else begin
        got = '{d: out_data, ch: out_ch, sop: out_sop, eop: out_eop};
        if (prev_stall) begin
          checks++;
          if (!out_valid || got != prev) begin
            errors++;
            $display("FAIL hold: got v=%0b %h ch%0d s%0b e%0b, required v=1 %h ch%0d s%0b e%0b",
                     out_valid, got.d, got.ch, got.sop, got.eop, prev.d, prev.ch, prev.sop, prev.eop);
          end
        end
        if (sync_err) serr_cnt++;
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %h ch%0d, required no output", out_data, out_ch);
          end else begin
            e = exp_q.pop_front();
            if (got != e) begin
              errors++;
              $display("FAIL byte%0d: got %h ch%0d sop%0b eop%0b, required %h ch%0d sop%0b eop%0b",
                       pops, got.d, got.ch, got.sop, got.eop, e.d, e.ch, e.sop, e.eop);
            end
          end
          if (out_sop && gap_chk && have_eop) begin
            checks++;
            if (cyc - last_eop != 2) begin
              errors++;
              $display("FAIL gap: got %0d idle cycles, required 1", cyc - last_eop - 1);
            end
          end
          if (out_eop) begin
            last_eop = cyc;
            have_eop = 1'b1;
          end
          pops++;
        end
        prev_stall = out_valid && !out_ready;
        prev       = got;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_pkt(input int ch, input int seed);
    for (int i = 0; i < PL; i++) srcq[ch].push_back(pb(seed, i));
  endtask

  task automatic expect_pkt(input int ch, input int seed);
    exp_t e;
    for (int i = 0; i < PL; i++) begin
      e.d = pb(seed, i); e.ch = 2'(ch); e.sop = (i == 0); e.eop = (i == PL - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_all();
    exp_q.delete();
    for (int k = 0; k < NCH; k++) srcq[k].delete();
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d bytes outstanding, required 0", tag, exp_q.size());
    end
    step(4);
  endtask

  task automatic chk_rst(input string tag);
    checks++;
    if ({out_valid, out_sop, out_eop, out_ch, out_data, sync_err, busy, in_ready} != '0) begin
      errors++;
      $display("FAIL %s: got v%0b s%0b e%0b ch%0d d%h se%0b busy%0b rdy%b, required all 0",
               tag, out_valid, out_sop, out_eop, out_ch, out_data, sync_err, busy, in_ready);
    end
  endtask

  initial begin
    int base, n, s0;

    // 1) ch0 only, two back-to-back packets; reset state checked first.
    rst = 1'b1; clear_all();
    ch_enable = 4'b0001; arb_mode = 1'b0;
    load_pkt(0, 0); load_pkt(0, 0);
    expect_pkt(0, 0); expect_pkt(0, 0);
    step(2);
    @(negedge clk);
    chk_rst("reset_state");
    @(posedge clk); #2;
    gap_chk = 1'b1;
    rst = 1'b0;
    wait_drain("t1", 1000);

    // 2) all channels valid, round-robin: 0,1,2,3,0.
    rst = 1'b1; clear_all();
    ch_enable = 4'b1111; arb_mode = 1'b0;
    load_pkt(0, 8'h10); load_pkt(0, 8'h50);
    load_pkt(1, 8'h20); load_pkt(2, 8'h30); load_pkt(3, 8'h40);
    expect_pkt(0, 8'h10); expect_pkt(1, 8'h20); expect_pkt(2, 8'h30);
    expect_pkt(3, 8'h40); expect_pkt(0, 8'h50);
    step(2); rst = 1'b0;
    wait_drain("t2", 2000);

    // 3) fixed priority, ch1 and ch3 valid: ch1 until it runs dry, then ch3.
    rst = 1'b1; clear_all();
    ch_enable = 4'b1010; arb_mode = 1'b1;
    load_pkt(1, 8'h21); load_pkt(1, 8'h61); load_pkt(3, 8'h43);
    expect_pkt(1, 8'h21); expect_pkt(1, 8'h61); expect_pkt(3, 8'h43);
    step(2); rst = 1'b0;
    wait_drain("t3", 1500);
    gap_chk = 1'b0;

    // 4) ch2 junk heads 12,34 discarded with two sync_err pulses, then a packet.
    rst = 1'b1; clear_all();
    ch_enable = 4'b0100; arb_mode = 1'b0;
    srcq[2].push_back(8'h12); srcq[2].push_back(8'h34);
    load_pkt(2, 8'h62); expect_pkt(2, 8'h62);
    step(2);
    s0 = serr_cnt;
    rst = 1'b0;
    wait_drain("t4", 1000);
    checks++;
    if (serr_cnt - s0 != 2) begin
      errors++;
      $display("FAIL sync_err_count: got %0d, required 2", serr_cnt - s0);
    end

    // 5) random out_ready over three packets.
    rst = 1'b1; clear_all();
    ch_enable = 4'b0111; arb_mode = 1'b0;
    load_pkt(0, 8'h05); load_pkt(1, 8'h15); load_pkt(2, 8'h25);
    expect_pkt(0, 8'h05); expect_pkt(1, 8'h15); expect_pkt(2, 8'h25);
    step(2); rst = 1'b0; rand_rdy = 1'b1;
    wait_drain("t5", 5000);
    rand_rdy = 1'b0;
    step(2);

    // 6) reset at byte 100 of the second ch1 packet; arbitration restarts at ch0.
    rst = 1'b1; clear_all();
    ch_enable = 4'b0010; arb_mode = 1'b0;
    load_pkt(1, 8'h31); load_pkt(1, 8'h71);
    expect_pkt(1, 8'h31); expect_pkt(1, 8'h71);
    step(2);
    base = pops;
    rst = 1'b0;
    n = 0;
    while (pops - base < PL + 100 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (pops - base < PL + 100) begin
      errors++;
      $display("FAIL reach_byte100: got %0d bytes, required %0d", pops - base, PL + 100);
    end
    #2;
    rst = 1'b1; clear_all();
    @(posedge clk);
    @(negedge clk);
    chk_rst("mid_packet_reset");
    ch_enable = 4'b0101;
    load_pkt(0, 8'h0A); load_pkt(2, 8'h2A);
    expect_pkt(0, 8'h0A); expect_pkt(2, 8'h2A);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_drain("t6", 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required completion");
    $fatal(1, "timeout");
  end

endmodule
